bus_arbiter: RTL

Shares the single `mmio` memory port (memread/memwrite/addr/writedata/readdata) between NREQ bus masters: the `cpu` core, plus later masters such as a switch/button debug loader or a DMA engine. It sits between the masters and `mmio` in the top level. Every master uses a req/ack handshake. The arbiter grants masters round-robin, issues exactly one memory strobe per transaction and returns read data with the ack.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/rr_picker.sv | 33 +++
 rtl/bus_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the mmio bus arbiter.
// Holds the FSM state encoding and a helper that sizes index/counter fields.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_DEF = 1;

  // $clog2 that never returns 0, so single-value fields still get one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first active request after last_grant,
// wrapping modulo NREQ, wins.
module rr_picker
  import bus_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  int               w_pos;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    w_pos  = 0;
    w_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = (int'(last_grant) + k) % NREQ;
      w_idx = IDX_W'(w_pos);
      if (!valid && req[w_idx]) begin
        valid  = 1'b1;
        winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the single mmio port among NREQ req/ack masters.
// One memory strobe per transaction; read data is returned alongside the ack.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*DATA_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      rdata,
  output logic                   memread,
  output logic                   memwrite,
  output logic [DATA_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_writedata,
  input  logic [DATA_W-1:0]      mem_readdata
);

  localparam int IDX_W = clog2_min1(NREQ);
  localparam int CNT_W = clog2_min1(RD_LAT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);
  localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(RD_LAT - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = NREQ'(1);

  state_e              r_state;
  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    r_winner;
  logic                r_we;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_memread;
  logic                r_memwrite;
  logic [NREQ-1:0]     r_ack;

  logic                w_valid;
  logic [IDX_W-1:0]    w_winner;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req),
    .last_grant (r_last_grant),
    .valid      (w_valid),
    .winner     (w_winner)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_grant <= LAST_RST;
      r_winner     <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_ack        <= '0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only in the one
      // cycle that needs them; later non-blocking writes in the case win.
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_ack      <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_winner   <= w_winner;
            r_we       <= we[w_winner];
            r_addr     <= addr[w_winner*DATA_W +: DATA_W];
            r_wdata    <= wdata[w_winner*DATA_W +: DATA_W];
            r_memread  <= !we[w_winner];
            r_memwrite <= we[w_winner];
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_last_grant <= r_winner;
          r_cnt        <= CNT_W'(1);
          if (RD_LAT == 1) begin
            r_ack   <= ONE_HOT0 << r_winner;
            r_state <= RESP;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == WAIT_END) begin
            r_ack   <= ONE_HOT0 << r_winner;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack           = r_ack;
  assign memread       = r_memread;
  assign memwrite      = r_memwrite;
  assign mem_addr      = r_addr;
  assign mem_writedata = r_wdata;
  // mmio data only becomes valid in the ack cycle itself, so it cannot be
  // registered here; it is gated straight through during RESP.
  assign rdata = (r_state == RESP && !r_we) ? mem_readdata : '0;

endmodule
